axi_sram_slave: RTL

AXI3 slave (responder) for the CPU's AXI master port. It accepts read and write bursts from the SRAM/AXI bridge and services them from a single-port synchronous SRAM. It is used as the memory model in the cache-enabled SoC and in the block-level testbench. It has one read FSM and one write FSM sharing the SRAM port under round-robin arbitration, with one outstanding transaction per direction.

---
 rtl/axi_sram_slave_if.sv | 64 ++++++
 rtl/axi_sram_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI3 channel bundle between the CPU-side master and the SRAM-backed slave.
// Carries the five channels: AR, R, AW, W and B.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving read and write bursts from a single-port synchronous
// SRAM. One read FSM and one write FSM share the SRAM port through a
// round-robin arbiter that only moves on conflicts. One outstanding
// transaction per direction.
module axi_sram_slave #(
    parameter int MEM_AW  = 16,
    parameter int MAX_LEN = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_sram_slave_if.slave   axi,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    // Largest legal beats-1 value; anything above is clipped and flagged.
    localparam logic [7:0] LEN_LIMIT = 8'(MAX_LEN - 1);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // Goes high on the first edge after reset release so the address
    // channels only open one edge later.
    logic              live_reg;

    r_state_t          r_state_reg, r_state_next;
    logic [3:0]        r_id_reg, r_id_next;
    logic [MEM_AW-1:0] r_addr_reg, r_addr_next;
    logic [7:0]        r_rem_reg, r_rem_next;
    logic              r_err_reg, r_err_next;
    logic              r_fixed_reg, r_fixed_next;
    logic [31:0]       r_data_reg, r_data_next;

    w_state_t          w_state_reg, w_state_next;
    logic [3:0]        w_id_reg, w_id_next;
    logic [MEM_AW-1:0] w_addr_reg, w_addr_next;
    logic [7:0]        w_rem_reg, w_rem_next;
    logic              w_err_reg, w_err_next;
    logic              w_fixed_reg, w_fixed_next;

    // 0: read wins the next conflict, 1: write wins it.
    logic              rr_ptr_reg, rr_ptr_next;

    logic rd_req, wr_req, grant_rd, grant_wr;
    logic w_end_rem, w_id_bad;

    // Address bits below the word and above the SRAM, plus beat size, play
    // no part in addressing.
    logic unused_bits;
    assign unused_bits = ^{axi.araddr[31:MEM_AW+2], axi.araddr[1:0], axi.arsize,
                           axi.awaddr[31:MEM_AW+2], axi.awaddr[1:0], axi.awsize};

    // Round-robin arbitration of the single SRAM port; pointer moves only
    // when both sides ask in the same cycle.
    always_comb begin
        rd_req      = (r_state_reg == R_REQ);
        wr_req      = (w_state_reg == W_DATA) && axi.wvalid;
        grant_rd    = rd_req && (!wr_req || !rr_ptr_reg);
        grant_wr    = wr_req && (!rd_req || rr_ptr_reg);
        rr_ptr_next = (rd_req && wr_req) ? !rr_ptr_reg : rr_ptr_reg;
    end

    // SRAM port mux: write beats pass straight through from the W handshake.
    always_comb begin
        sram_en    = grant_rd || grant_wr;
        sram_we    = grant_wr ? axi.wstrb : 4'b0000;
        sram_addr  = grant_wr ? w_addr_reg : r_addr_reg;
        sram_wdata = grant_wr ? axi.wdata : 32'h0;
    end

    // Read FSM next state and datapath.
    always_comb begin
        r_state_next = r_state_reg;
        r_id_next    = r_id_reg;
        r_addr_next  = r_addr_reg;
        r_rem_next   = r_rem_reg;
        r_err_next   = r_err_reg;
        r_fixed_next = r_fixed_reg;
        r_data_next  = r_data_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (live_reg && axi.arvalid) begin
                    r_id_next    = axi.arid;
                    r_addr_next  = axi.araddr[MEM_AW+1:2];
                    r_rem_next   = (axi.arlen > LEN_LIMIT) ? LEN_LIMIT : axi.arlen;
                    r_err_next   = (axi.arlen > LEN_LIMIT);
                    r_fixed_next = (axi.arburst == 2'b00);
                    r_state_next = R_REQ;
                end
            end
            R_REQ: begin
                if (grant_rd) r_state_next = R_WAIT;
            end
            R_WAIT: begin
                r_data_next  = sram_rdata;
                r_state_next = R_DATA;
            end
            R_DATA: begin
                if (axi.rready) begin
                    if (r_rem_reg == 8'd0) begin
                        r_state_next = R_IDLE;
                    end else begin
                        r_rem_next   = r_rem_reg - 8'd1;
                        r_addr_next  = r_addr_reg + (r_fixed_reg ? MEM_AW'(0) : MEM_AW'(1));
                        r_state_next = R_REQ;
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read channel outputs; held stable by the registers during R_DATA.
    always_comb begin
        axi.arready = live_reg && (r_state_reg == R_IDLE);
        axi.rvalid  = (r_state_reg == R_DATA);
        axi.rlast   = (r_state_reg == R_DATA) && (r_rem_reg == 8'd0);
        axi.rresp   = ((r_state_reg == R_DATA) && r_err_reg) ? 2'b10 : 2'b00;
        axi.rid     = r_id_reg;
        axi.rdata   = r_data_reg;
    end

    // Write FSM next state and datapath; a beat is consumed only when granted.
    always_comb begin
        w_state_next = w_state_reg;
        w_id_next    = w_id_reg;
        w_addr_next  = w_addr_reg;
        w_rem_next   = w_rem_reg;
        w_err_next   = w_err_reg;
        w_fixed_next = w_fixed_reg;
        w_end_rem    = (w_rem_reg == 8'd0);
        w_id_bad     = (axi.wid != w_id_reg);
        case (w_state_reg)
            W_IDLE: begin
                if (live_reg && axi.awvalid) begin
                    w_id_next    = axi.awid;
                    w_addr_next  = axi.awaddr[MEM_AW+1:2];
                    w_rem_next   = (axi.awlen > LEN_LIMIT) ? LEN_LIMIT : axi.awlen;
                    w_err_next   = (axi.awlen > LEN_LIMIT);
                    w_fixed_next = (axi.awburst == 2'b00);
                    w_state_next = W_DATA;
                end
            end
            W_DATA: begin
                if (grant_wr) begin
                    w_err_next  = w_err_reg || w_id_bad;
                    w_rem_next  = w_rem_reg - 8'd1;
                    w_addr_next = w_addr_reg + (w_fixed_reg ? MEM_AW'(0) : MEM_AW'(1));
                    // Burst closes on whichever of wlast / count runs out first;
                    // disagreement between the two is an error.
                    if (axi.wlast || w_end_rem) begin
                        w_err_next   = w_err_reg || w_id_bad || (axi.wlast != w_end_rem);
                        w_state_next = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi.bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write channel outputs.
    always_comb begin
        axi.awready = live_reg && (w_state_reg == W_IDLE);
        axi.wready  = grant_wr;
        axi.bvalid  = (w_state_reg == W_RESP);
        axi.bid     = w_id_reg;
        axi.bresp   = ((w_state_reg == W_RESP) && w_err_reg) ? 2'b10 : 2'b00;
    end

    // State registers; reset drops any burst in flight without a response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live_reg    <= 1'b0;
            rr_ptr_reg  <= 1'b0;
            r_state_reg <= R_IDLE;
            r_id_reg    <= 4'd0;
            r_addr_reg  <= '0;
            r_rem_reg   <= 8'd0;
            r_err_reg   <= 1'b0;
            r_fixed_reg <= 1'b0;
            r_data_reg  <= 32'h0;
            w_state_reg <= W_IDLE;
            w_id_reg    <= 4'd0;
            w_addr_reg  <= '0;
            w_rem_reg   <= 8'd0;
            w_err_reg   <= 1'b0;
            w_fixed_reg <= 1'b0;
        end else begin
            live_reg    <= 1'b1;
            rr_ptr_reg  <= rr_ptr_next;
            r_state_reg <= r_state_next;
            r_id_reg    <= r_id_next;
            r_addr_reg  <= r_addr_next;
            r_rem_reg   <= r_rem_next;
            r_err_reg   <= r_err_next;
            r_fixed_reg <= r_fixed_next;
            r_data_reg  <= r_data_next;
            w_state_reg <= w_state_next;
            w_id_reg    <= w_id_next;
            w_addr_reg  <= w_addr_next;
            w_rem_reg   <= w_rem_next;
            w_err_reg   <= w_err_next;
            w_fixed_reg <= w_fixed_next;
        end
    end

endmodule
